// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder: FSM encoding, slice width,
// and the bit-level ripple and overflow functions used by the datapath.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Bit-by-bit ripple add of one nibble; returns {carry, sum}.
    function automatic logic [NIBBLE_W:0] ripple_add(
        input logic [NIBBLE_W-1:0] x,
        input logic [NIBBLE_W-1:0] y,
        input logic                ci
    );
        logic                c;
        logic [NIBBLE_W-1:0] s;
        c = ci;
        s = {NIBBLE_W{1'b0}};
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic calc_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// 4-bit carry-select adder slice: both carry-in cases are precomputed by two
// ripple adders and the real carry-in picks one.
module csa_4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out
);

    logic [NIBBLE_W:0] res0_s;
    logic [NIBBLE_W:0] res1_s;

    // Speculative ripple results for carry-in 0 and 1.
    always_comb begin
        res0_s = ripple_add(A, B, 1'b0);
        res1_s = ripple_add(A, B, 1'b1);
    end

    // Carry-in selects the precomputed result.
    always_comb begin
        if (c_in) begin
            sum   = res1_s[NIBBLE_W-1:0];
            c_out = res1_s[NIBBLE_W];
        end else begin
            sum   = res0_s[NIBBLE_W-1:0];
            c_out = res0_s[NIBBLE_W];
        end
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial add/subtract: operands are captured once, then consumed four bits
// per cycle through a single carry-select slice; the result is held until taken.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NIB    = WIDTH / 4;
    localparam int STEP_W = $clog2(NIB);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIB - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [WIDTH-1:0]    a_sh_r;
    logic [WIDTH-1:0]    b_sh_r;
    logic [WIDTH-1:0]    res_r;
    logic                carry_r;
    logic                sub_r;
    logic [STEP_W-1:0]   step_r;
    logic                c_out_r;
    logic                ovf_r;
    logic                last_step_s;
    logic                slice_cin_s;
    logic [NIBBLE_W-1:0] slice_sum_s;
    logic                slice_c_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign sum       = res_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;

    // Step decode and slice carry-in; the first step takes the subtract flag directly.
    always_comb begin
        last_step_s = (step_r == LAST_STEP);
        if (step_r == {STEP_W{1'b0}}) begin
            slice_cin_s = sub_r;
        end else begin
            slice_cin_s = carry_r;
        end
    end

    csa_4 u_slice (
        .A     (a_sh_r[NIBBLE_W-1:0]),
        .B     (b_sh_r[NIBBLE_W-1:0]),
        .c_in  (slice_cin_s),
        .sum   (slice_sum_s),
        .c_out (slice_c_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: accept in IDLE, run NIB steps, hold DONE until taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_step_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, per-step shifting, and final flag registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
            step_r  <= {STEP_W{1'b0}};
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b ^ {WIDTH{sub}};
                        sub_r   <= sub;
                        carry_r <= sub;
                        step_r  <= {STEP_W{1'b0}};
                    end
                end
                BUSY: begin
                    a_sh_r  <= {{NIBBLE_W{1'b0}}, a_sh_r[WIDTH-1:NIBBLE_W]};
                    b_sh_r  <= {{NIBBLE_W{1'b0}}, b_sh_r[WIDTH-1:NIBBLE_W]};
                    res_r   <= {slice_sum_s, res_r[WIDTH-1:NIBBLE_W]};
                    carry_r <= slice_c_s;
                    // Counter parks on the last step so it never wraps mid-operation.
                    if (last_step_s) begin
                        c_out_r <= slice_c_s;
                        ovf_r   <= calc_ovf(a_sh_r[NIBBLE_W-1], b_sh_r[NIBBLE_W-1],
                                            slice_sum_s[NIBBLE_W-1]);
                    end else begin
                        step_r  <= step_r + STEP_ONE;
                    end
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases, hold and
// reset scenarios, then a random streamed run against an arithmetic model.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int n_assert = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, c_out, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        logic [W-1:0] ey;
        logic [W:0]   r;
        logic         v;
        ey = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ey} + {{W{1'b0}}, s};
        v  = (x[W-1] == ey[W-1]) && (r[W-1] != x[W-1]);
        return {v, r};
    endfunction

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic [W+1:0] exp, input bit release_out);
        int lat;
        chk({tag, "_in_ready"}, in_ready, 1);
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_sum"}, sum, exp[W-1:0]);
        chk({tag, "_c_out"}, c_out, exp[W]);
        chk({tag, "_ovf"}, ovf, exp[W+1]);
        chk({tag, "_busy_in_ready"}, in_ready, 0);
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tag, "_rel_out_valid"}, out_valid, 0);
            chk({tag, "_rel_in_ready"}, in_ready, 1);
        end
    endtask

    initial begin
        logic [W+1:0] e;
        logic [W+1:0] q[$];
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        int acc, done_n, cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_1234", 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}, 1'b1);
        do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}, 1'b1);
        do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}, 1'b1);
        do_op("sub_5m7",  16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 1'b1);
        do_op("sub_8000", 16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 1'b1);

        for (int i = 0; i < 4; i++) begin
            x = W'($urandom); y = W'($urandom); s = 1'($urandom_range(0, 1));
            do_op("rand_directed", x, y, s, ref_op(x, y, s), 1'b1);
        end

        // DONE held with out_ready low while inputs wiggle.
        do_op("hold", 16'h00FF, 16'h0F01, 1'b0, {1'b0, 1'b0, 16'h1000}, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            @(posedge clk); #1;
            chk("hold_sum", sum, 16'h1000);
            chk("hold_c_out", c_out, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_release_in_ready", in_ready, 1);
        chk("hold_release_out_valid", out_valid, 0);

        // Reset dropped after two steps of an operation.
        a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_c_out", c_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op("post_rst", 16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002}, 1'b1);

        // Streamed random operations with in_valid held high.
        acc = 0; done_n = 0; cyc = 0;
        in_valid = 1'b1;
        while ((acc < 100 || done_n < acc) && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("stream_sum", sum, e[W-1:0]);
                    chk("stream_c_out", c_out, e[W]);
                    chk("stream_ovf", ovf, e[W+1]);
                    done_n++;
                end
            end
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
            if (in_ready) begin
                if (acc < 100) begin
                    q.push_back(ref_op(a, b, sub));
                    acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_completed", done_n, 100);
        chk("stream_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; it SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have localparam NIB, value WIDTH/4, the number of nibble steps.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b, sub are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port sub, input, 1 bit: 0 computes A+B, 1 computes A-B.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port sum, output, WIDTH bits: result.
REQ-013 SHALL have port c_out, output, 1 bit: carry out of the MSB; for subtract, 1 means no borrow.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 An acceptance is a rising edge with in_valid=1 and in_ready=1; on acceptance the block SHALL register a, the effective B (b XOR {WIDTH{sub}}), the sub flag, carry register = sub, step counter = 0, and enter BUSY.
REQ-018 In BUSY, each cycle SHALL add the low nibble of the A and B shift registers plus the carry register through one 4-bit carry-select slice.
REQ-019 Each BUSY cycle SHALL shift both operand registers right by 4 bits, shift the 4-bit slice sum into the top nibble of the result register, store the slice carry in the carry register, and increment the step counter.
REQ-020 After step NIB-1 completes, the FSM SHALL enter DONE; out_valid SHALL therefore rise exactly NIB cycles after the acceptance edge (4 cycles at WIDTH=16).
REQ-021 In DONE, sum, c_out and ovf SHALL be held stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-022 out_ready=0 SHALL hold DONE indefinitely, with outputs unchanged.
REQ-023 in_valid SHALL be ignored in BUSY and DONE.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 ovf SHALL be 1 when A[MSB] equals effective-B[MSB] and sum[MSB] differs from A[MSB]; it SHALL be computed once at the final step and registered.
REQ-026 Carry-out from step NIB-1 SHALL be c_out; intermediate carries SHALL NOT be visible on ports.
REQ-027 The step counter SHALL be sized $clog2(NIB) and SHALL NOT wrap inside one operation.

Reset
REQ-028 On rst_n=0, immediately and regardless of clk: FSM=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, all internal registers 0.
REQ-029 Reset asserted mid-operation (BUSY or DONE) SHALL abandon the operation with no result emitted.
REQ-030 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (2-bit encoding: IDLE=0, BUSY=1, DONE=2) and the constant NIBBLE_W=4.
REQ-032 The adder slice SHALL be one sub-module instance, csa_4 (4-bit carry-select adder: two 4-bit ripple adders with carry-in 0 and 1, selected by carry-in), ports A[3:0], B[3:0], c_in, sum[3:0], c_out.
REQ-033 No other arithmetic operator SHALL be used on the datapath.

Verification
REQ-034 Add 0x1234 + 0x4321 -> after 4 cycles sum=0x5555, c_out=0, ovf=0.
REQ-035 Add 0xFFFF + 0x0001 -> sum=0x0000, c_out=1, ovf=0; then add 0x7FFF + 0x0001 -> sum=0x8000, c_out=0, ovf=1.
REQ-036 Subtract 0x0005 - 0x0007 -> sum=0xFFFE, c_out=0, ovf=0; then subtract 0x8000 - 0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
REQ-037 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and a -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 Assert rst_n=0 at step 2 of an operation -> out_valid=0 and sum=0 immediately; after release, add 0x0001 + 0x0001 -> sum=0x0002 with correct latency.
REQ-039 Back-to-back stream of 100 random add/sub operations with in_valid held high and out_ready random -> every result matches a reference model and no operation is lost or duplicated.
